imem_loader: RTL and testbench

- Boot-time writer for the instruction memory that the core fetches from.
- Accepts a byte stream over a valid/ready interface and assembles little-endian 32-bit words.
- Writes each word into the IMEM write port at consecutive word addresses.
- Holds the core stopped (core_run=0) until the image is fully written, then releases it.

---
 rtl/imem_loader.sv | 133 +++++++++++++
 tb/tb_imem_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time IMEM writer: a length-prefixed byte stream becomes little-endian 32-bit word writes, then the core is released.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before release.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_run,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, DONE, ERROR} state_t;
  localparam state_t END_ST = CSUM;
`else
  typedef enum logic [2:0] {HDR0, HDR1, DATA, DONE, ERROR} state_t;
  localparam state_t END_ST = DONE;
`endif
  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  state_t            state_q, state_d;
  logic              in_ready_q, busy_q, imem_we_q, core_run_q, err_q;
  logic [ADDR_W-1:0] imem_waddr_q;
  logic [31:0]       imem_wdata_q;
  logic [ADDR_W:0]   words_written_q;
  logic [7:0]        cnt_lo_q;
  logic [15:0]       cnt_q;
  logic [1:0]        idx_q;
  logic [23:0]       part_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        xsum_q;
`endif

  logic        accept, last_word, active_d, restart;
  logic [16:0] hdr_cnt;

  assign accept   = in_valid & in_ready_q;
  assign hdr_cnt  = {1'b0, in_data, cnt_lo_q};
  // words_written trails each write by one cycle, so on a 4th byte it equals this word's index
  assign last_word = (17'(words_written_q) + 17'd1) == {1'b0, cnt_q};
  assign restart  = reload & ((state_q == DONE) || (state_q == ERROR));
  assign active_d = !((state_d == DONE) || (state_d == ERROR));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR0:  if (accept) state_d = HDR1;
      HDR1:  if (accept) begin
               if (hdr_cnt == 17'd0)  state_d = END_ST;
               else if (hdr_cnt > CAP) state_d = ERROR;
               else                   state_d = DATA;
             end
      DATA:  if (accept && idx_q == 2'd3 && last_word) state_d = END_ST;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM:  if (accept) state_d = (in_data == xsum_q) ? DONE : ERROR;
`endif
      DONE, ERROR: if (reload) state_d = HDR0;
      default: state_d = HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= HDR0;
      in_ready_q      <= 1'b0;
      busy_q          <= 1'b0;
      imem_we_q       <= 1'b0;
      imem_waddr_q    <= '0;
      imem_wdata_q    <= '0;
      core_run_q      <= 1'b0;
      err_q           <= 1'b0;
      words_written_q <= '0;
      cnt_lo_q        <= '0;
      cnt_q           <= '0;
      idx_q           <= '0;
      part_q          <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xsum_q          <= '0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= active_d;
      busy_q     <= active_d;
      imem_we_q  <= 1'b0;
      if (imem_we_q) words_written_q <= words_written_q + (ADDR_W+1)'(1);
      if (accept && state_q == HDR0) cnt_lo_q <= in_data;
      if (accept && state_q == HDR1) cnt_q <= {in_data, cnt_lo_q};
      if (accept && state_q == DATA) begin
        idx_q  <= idx_q + 2'd1;
        part_q <= {in_data, part_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
        xsum_q <= xsum_q ^ in_data;
`endif
        if (idx_q == 2'd3) begin
          imem_we_q    <= 1'b1;
          imem_waddr_q <= words_written_q[ADDR_W-1:0];
          imem_wdata_q <= {in_data, part_q};
        end
      end
      if (state_d == ERROR) err_q <= 1'b1;
      if (state_q == DONE)  core_run_q <= 1'b1;
      if (restart) begin
        core_run_q      <= 1'b0;
        err_q           <= 1'b0;
        words_written_q <= '0;
        imem_waddr_q    <= '0;
        idx_q           <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xsum_q          <= '0;
`endif
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign busy          = busy_q;
  assign imem_we       = imem_we_q;
  assign imem_waddr    = imem_waddr_q;
  assign imem_wdata    = imem_wdata_q;
  assign core_run      = core_run_q;
  assign err           = err_q;
  assign words_written = words_written_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, gaps, zero/overflow counts, reset mid-load, reload, full capacity.
// Checksum cases run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, reload = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready, imem_we, core_run, busy, err;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   words_written;

  int checks = 0, errors = 0;
  logic [7:0]        frame[$];
  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .reload(reload), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_run(core_run), .busy(busy), .err(err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we) begin
    wa.push_back(imem_waddr);
    wd.push_back(imem_wdata);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    in_data = b; in_valid = 1'b1;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input int gap, input bit add_csum);
    logic [7:0] x = 8'h00;
    foreach (frame[i]) begin
      send_byte(frame[i], gap);
      if (i >= 2) x ^= frame[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (add_csum) send_byte(x, gap);
`else
    if (add_csum && x === 8'hxx) $display("unreachable");
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; reload = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_rdy"},  64'(in_ready), 64'd0);
    check({tag, "_we"},   64'(imem_we), 64'd0);
    check({tag, "_addr"}, 64'(imem_waddr), 64'd0);
    check({tag, "_data"}, 64'(imem_wdata), 64'd0);
    check({tag, "_run"},  64'(core_run), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_err"},  64'(err), 64'd0);
    check({tag, "_ww"},   64'(words_written), 64'd0);
  endtask

  task automatic pulse_reload();
    reload = 1'b1; @(negedge clk); reload = 1'b0;
  endtask

  task automatic chk_two(input string tag, input logic [31:0] d0, input logic [31:0] d1);
    check({tag, "_nwr"}, 64'(wa.size()), 64'd2);
    if (wa.size() >= 2) begin
      check({tag, "_a0"}, 64'(wa[0]), 64'd0);
      check({tag, "_d0"}, 64'(wd[0]), 64'(d0));
      check({tag, "_a1"}, 64'(wa[1]), 64'd1);
      check({tag, "_d1"}, 64'(wd[1]), 64'(d1));
    end
    check({tag, "_ww"},   64'(words_written), 64'd2);
    check({tag, "_run"},  64'(core_run), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_rdy"},  64'(in_ready), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int bad;
    logic [7:0] i8;
    // basic load with continuous valid
    do_reset(); chk_reset_vals("rst");
    wa.delete(); wd.delete();
    rst_n = 1'b1; @(negedge clk);
    check("rdy_after_rst", 64'(in_ready), 64'd1);
    check("busy_after_rst", 64'(busy), 64'd1);
    frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    send_frame(0, 1'b1);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("basic_we_last", 64'(imem_we), 64'd1);
    check("basic_run_pre", 64'(core_run), 64'd0);
    @(negedge clk);
    check("basic_run_post", 64'(core_run), 64'd1);
    check("basic_we_single", 64'(imem_we), 64'd0);
`endif
    repeat (3) @(negedge clk);
    chk_two("basic", 32'h00A00513, 32'h00B00593);

    // gapped valid
    do_reset(); wa.delete(); wd.delete(); rst_n = 1'b1;
    send_frame(3, 1'b1);
    repeat (5) @(negedge clk);
    chk_two("gap", 32'h00A00513, 32'h00B00593);

    // N = 0
    do_reset(); wa.delete(); wd.delete(); rst_n = 1'b1;
    frame = '{8'h00, 8'h00};
    send_frame(0, 1'b1);
    check("zero_run_pre", 64'(core_run), 64'd0);
    @(negedge clk);
    check("zero_run_post", 64'(core_run), 64'd1);
    repeat (2) @(negedge clk);
    check("zero_nwr", 64'(wa.size()), 64'd0);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_rdy", 64'(in_ready), 64'd0);

    // N = 257 overflow, then bytes while not ready, then reload
    do_reset(); wa.delete(); wd.delete(); rst_n = 1'b1;
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    repeat (2) @(negedge clk);
    check("ovf_err", 64'(err), 64'd1);
    check("ovf_rdy", 64'(in_ready), 64'd0);
    check("ovf_run", 64'(core_run), 64'd0);
    check("ovf_busy", 64'(busy), 64'd0);
    in_data = 8'h55; in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("ovf_nwr", 64'(wa.size()), 64'd0);
    check("ovf_err_sticky", 64'(err), 64'd1);
    pulse_reload();
    check("ovf_reload_err", 64'(err), 64'd0);
    check("ovf_reload_rdy", 64'(in_ready), 64'd1);
    frame = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(0, 1'b1);
    repeat (3) @(negedge clk);
    check("ovf_after_nwr", 64'(wa.size()), 64'd1);
    if (wa.size() >= 1) check("ovf_after_d0", 64'(wd[0]), 64'h44332211);

    // reset mid-load after 6 bytes
    do_reset(); wa.delete(); wd.delete(); rst_n = 1'b1;
    frame = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (frame[k]) send_byte(frame[k], 0);
    do_reset(); chk_reset_vals("midrst");
    check("midrst_nwr", 64'(wa.size()), 64'd1);
    if (wa.size() >= 1) check("midrst_a0", 64'(wa[0]), 64'd0);
    wa.delete(); wd.delete(); rst_n = 1'b1;
    frame = '{8'h02, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(0, 1'b1);
    repeat (3) @(negedge clk);
    chk_two("midrst_reload", 32'hD4C3B2A1, 32'h04030201);

    // reload from DONE; reload mid-frame is ignored
    pulse_reload();
    check("rl_run", 64'(core_run), 64'd0);
    check("rl_rdy", 64'(in_ready), 64'd1);
    check("rl_ww", 64'(words_written), 64'd0);
    wa.delete(); wd.delete();
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'hEF, 0);
    pulse_reload();
    send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE, 0);
`endif
    repeat (3) @(negedge clk);
    check("rl_nwr", 64'(wa.size()), 64'd1);
    if (wa.size() >= 1) begin
      check("rl_a0", 64'(wa[0]), 64'd0);
      check("rl_d0", 64'(wd[0]), 64'hDEADBEEF);
    end
    check("rl_ww1", 64'(words_written), 64'd1);
    check("rl_run1", 64'(core_run), 64'd1);

    // full capacity N = 2^ADDR_W
    do_reset(); wa.delete(); wd.delete(); rst_n = 1'b1;
    frame = '{8'h00, 8'h01};
    for (int i = 0; i < 256; i++) begin
      i8 = 8'(i);
      frame.push_back(i8); frame.push_back(i8 ^ 8'h5A); frame.push_back(~i8); frame.push_back(8'hC3);
    end
    send_frame(0, 1'b1);
    repeat (3) @(negedge clk);
    check("full_nwr", 64'(wa.size()), 64'd256);
    bad = 0;
    foreach (wa[i]) begin
      i8 = 8'(i);
      if (wa[i] !== 8'(i) || wd[i] !== {8'hC3, ~i8, i8 ^ 8'h5A, i8}) bad++;
    end
    check("full_bad_words", 64'(bad), 64'd0);
    check("full_ww", 64'(words_written), 64'd256);
    check("full_last_addr", 64'(imem_waddr), 64'd255);
    check("full_run", 64'(core_run), 64'd1);
    check("full_err", 64'(err), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // checksum match and mismatch
    do_reset(); wa.delete(); wd.delete(); rst_n = 1'b1;
    frame = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_frame(0, 1'b0);
    repeat (3) @(negedge clk);
    check("cs_ok_run", 64'(core_run), 64'd1);
    check("cs_ok_err", 64'(err), 64'd0);
    do_reset(); wa.delete(); wd.delete(); rst_n = 1'b1;
    frame = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_frame(0, 1'b0);
    repeat (3) @(negedge clk);
    check("cs_bad_err", 64'(err), 64'd1);
    check("cs_bad_run", 64'(core_run), 64'd0);
    check("cs_bad_nwr", 64'(wa.size()), 64'd1);
    if (wa.size() >= 1) check("cs_bad_d0", 64'(wd[0]), 64'h44332211);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
